// File: rtl/rr_arb4_if.sv
// Bundle of request, payload and downstream handshake signals for the
// four-channel round-robin arbiter.
interface rr_arb4_if #(
   parameter int WIDTH = 8
);
   logic [3:0]       i_valid;
   logic [WIDTH-1:0] i_data_0;
   logic [WIDTH-1:0] i_data_1;
   logic [WIDTH-1:0] i_data_2;
   logic [WIDTH-1:0] i_data_3;
   logic [3:0]       o_ready;
   logic             o_valid;
   logic [WIDTH-1:0] o_data;
   logic [1:0]       o_sel;
   logic             i_ready;

   // Arbiter side: consumes requests and downstream ready, drives the output register.
   modport slave (
      input  i_valid, i_data_0, i_data_1, i_data_2, i_data_3, i_ready,
      output o_ready, o_valid, o_data, o_sel
   );

   // Environment side: the requesters and the downstream consumer.
   modport master (
      output i_valid, i_data_0, i_data_1, i_data_2, i_data_3, i_ready,
      input  o_ready, o_valid, o_data, o_sel
   );
endinterface

// File: rtl/rr_arb4.sv
// Four-channel round-robin arbiter feeding a single registered output stage
// that sustains one word per cycle under continuous downstream accept.
module rr_arb4 #(
   parameter int WIDTH = 8
) (
   input logic     i_clk,
   input logic     i_rst,
   rr_arb4_if.slave bus
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t           state;
   state_t           state_next;
   logic [1:0]       ptr;
   logic [1:0]       win;
   logic             any_req;
   logic             load;
   logic             take;
   logic [WIDTH-1:0] win_data;
   logic [WIDTH-1:0] data_q;
   logic [1:0]       sel_q;

   // Search starts at the pointer and wraps, so the channel after the last winner has priority.
   always_comb begin
      logic [1:0] idx;
      any_req = 1'b0;
      win     = 2'd0;
      idx     = 2'd0;
      for (int i = 0; i < 4; i++) begin
         idx = ptr + 2'(i);
         if (!any_req && bus.i_valid[idx]) begin
            any_req = 1'b1;
            win     = idx;
         end
      end
   end

   always_comb begin
      win_data = bus.i_data_0;
      case (win)
         2'd0: win_data = bus.i_data_0;
         2'd1: win_data = bus.i_data_1;
         2'd2: win_data = bus.i_data_2;
         2'd3: win_data = bus.i_data_3;
         default: win_data = bus.i_data_0;
      endcase
   end

   // The output register can take a new word when empty or when it is being drained this cycle.
   assign load        = (state == EMPTY) || bus.i_ready;
   assign take        = any_req && load && !i_rst;
   assign bus.o_ready = take ? (4'b0001 << win) : 4'b0000;

   always_comb begin
      state_next = state;
      case (state)
         EMPTY: if (take) state_next = FULL;
         FULL:  if (bus.i_ready && !take) state_next = EMPTY;
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= EMPTY;
      else       state <= state_next;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         data_q <= '0;
         sel_q  <= 2'd0;
         ptr    <= 2'd0;
      end else if (take) begin
         data_q <= win_data;
         sel_q  <= win;
         ptr    <= win + 2'd1;
      end
   end

   assign bus.o_valid = (state == FULL);
   assign bus.o_data  = data_q;
   assign bus.o_sel   = sel_q;

endmodule
